cv32e40x_xif_result_buffer: RTL and testbench

CV32E40X_XIF_RESULT_BUFFER -- requirements
Module: cv32e40x_xif_result_buffer

---
 rtl/cv32e40x_xif_result_buffer.sv | 150 +++++++++++++++
 tb/tb_cv32e40x_xif_result_buffer.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cv32e40x_xif_result_buffer.sv
// XIF result buffer for an offloaded functional unit.
//
// Results from the functional unit are queued in arrival order and only offered on the XIF
// result interface once the core has committed the instruction. Commits or kills that arrive
// before the result are remembered in a per-ID scoreboard and applied when the result is pushed.
//
// Ports:
//   clk_i, rst_i                       clock, synchronous active-high reset
//   fu_valid_i/fu_ready_o/fu_id_i/fu_rd_i/fu_data_i
//                                      result push from the functional unit
//   commit_valid_i/commit_id_i/commit_kill_i
//                                      commit (kill=0) or kill (kill=1) for an instruction ID
//   result_valid_o/result_ready_i/result_id_o/result_rd_o/result_data_o/result_we_o
//                                      XIF result interface
//   count_o                            number of occupied entries
module cv32e40x_xif_result_buffer #(
  parameter int unsigned DEPTH       = 4,
  parameter int unsigned X_ID_WIDTH  = 4,
  parameter int unsigned X_RFW_WIDTH = 32
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     fu_valid_i,
  output logic                     fu_ready_o,
  input  logic [X_ID_WIDTH-1:0]    fu_id_i,
  input  logic [4:0]               fu_rd_i,
  input  logic [X_RFW_WIDTH-1:0]   fu_data_i,
  input  logic                     commit_valid_i,
  input  logic [X_ID_WIDTH-1:0]    commit_id_i,
  input  logic                     commit_kill_i,
  output logic                     result_valid_o,
  input  logic                     result_ready_i,
  output logic [X_ID_WIDTH-1:0]    result_id_o,
  output logic [4:0]               result_rd_o,
  output logic [X_RFW_WIDTH-1:0]   result_data_o,
  output logic                     result_we_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int unsigned PtrW   = $clog2(DEPTH);
  localparam int unsigned NumIds = 2 ** X_ID_WIDTH;
  localparam logic [PtrW:0] DepthCnt = (PtrW + 1)'(DEPTH);

  typedef enum logic [1:0] {StFree, StWaitCommit, StReady, StKilled} entry_state_e;

  entry_state_e             state_q [DEPTH];
  logic [X_ID_WIDTH-1:0]    id_q    [DEPTH];
  logic [4:0]               rd_q    [DEPTH];
  logic [X_RFW_WIDTH-1:0]   data_q  [DEPTH];
  logic [PtrW-1:0]          head_q, tail_q;
  logic [PtrW:0]            count_q;
  logic [NumIds-1:0]        sb_commit_q, sb_kill_q;

  logic                     push, pop, discard, remove;
  logic                     cmt_hit, cmt_to_push;
  logic [PtrW-1:0]          cmt_idx;
  entry_state_e             push_state;

  // Find an occupied entry carrying the committed ID. A hit on an entry that is already
  // READY or KILLED swallows the event so it never lands in the scoreboard.
  always_comb begin
    cmt_hit = 1'b0;
    cmt_idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (state_q[i] != StFree && id_q[i] == commit_id_i) begin
        cmt_hit = 1'b1;
        cmt_idx = PtrW'(i);
      end
    end
  end

  always_comb begin
    push        = fu_valid_i && fu_ready_o;
    pop         = result_valid_o && result_ready_i;
    discard     = state_q[head_q] == StKilled;
    remove      = pop || discard;
    // A commit racing the push of the same ID is folded straight into the new entry.
    cmt_to_push = commit_valid_i && push && !cmt_hit && (fu_id_i == commit_id_i);
    if (cmt_to_push) begin
      push_state = commit_kill_i ? StKilled : StReady;
    end else if (sb_kill_q[fu_id_i]) begin
      push_state = StKilled;
    end else if (sb_commit_q[fu_id_i]) begin
      push_state = StReady;
    end else begin
      push_state = StWaitCommit;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        state_q[i] <= StFree;
        id_q[i]    <= '0;
        rd_q[i]    <= '0;
        data_q[i]  <= '0;
      end
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      sb_commit_q <= '0;
      sb_kill_q   <= '0;
    end else begin
      if (commit_valid_i) begin
        if (cmt_hit) begin
          if (state_q[cmt_idx] == StWaitCommit) begin
            state_q[cmt_idx] <= commit_kill_i ? StKilled : StReady;
          end
        end else if (!cmt_to_push) begin
          if (commit_kill_i) begin
            sb_kill_q[commit_id_i] <= 1'b1;
          end else begin
            sb_commit_q[commit_id_i] <= 1'b1;
          end
        end
      end
      // Removal only touches READY/KILLED heads and the commit update only WAIT_COMMIT
      // entries, so the two never target the same slot; push targets a FREE tail.
      if (remove) begin
        state_q[head_q] <= StFree;
        head_q          <= head_q + 1'b1;
      end
      if (push) begin
        state_q[tail_q]      <= push_state;
        id_q[tail_q]         <= fu_id_i;
        rd_q[tail_q]         <= fu_rd_i;
        data_q[tail_q]       <= fu_data_i;
        tail_q               <= tail_q + 1'b1;
        sb_commit_q[fu_id_i] <= 1'b0;
        sb_kill_q[fu_id_i]   <= 1'b0;
      end
      if (push && !remove) begin
        count_q <= count_q + 1'b1;
      end else if (!push && remove) begin
        count_q <= count_q - 1'b1;
      end
    end
  end

  always_comb begin
    fu_ready_o     = count_q < DepthCnt;
    count_o        = count_q;
    result_valid_o = state_q[head_q] == StReady;
    result_we_o    = result_valid_o;
    result_id_o    = result_valid_o ? id_q[head_q]   : '0;
    result_rd_o    = result_valid_o ? rd_q[head_q]   : '0;
    result_data_o  = result_valid_o ? data_q[head_q] : '0;
  end

endmodule

// File: tb/tb_cv32e40x_xif_result_buffer.sv
module tb_cv32e40x_xif_result_buffer;

  logic        clk;
  logic        rst_i;
  logic        fu_valid;
  logic        fu_ready;
  logic [3:0]  fu_id;
  logic [4:0]  fu_rd;
  logic [31:0] fu_data;
  logic        commit_valid;
  logic [3:0]  commit_id;
  logic        commit_kill;
  logic        result_valid;
  logic        result_ready;
  logic [3:0]  result_id;
  logic [4:0]  result_rd;
  logic [31:0] result_data;
  logic        result_we;
  logic [2:0]  count;

  int errors;
  int checks;

  cv32e40x_xif_result_buffer #(
    .DEPTH       (4),
    .X_ID_WIDTH  (4),
    .X_RFW_WIDTH (32)
  ) dut (
    .clk_i          (clk),
    .rst_i          (rst_i),
    .fu_valid_i     (fu_valid),
    .fu_ready_o     (fu_ready),
    .fu_id_i        (fu_id),
    .fu_rd_i        (fu_rd),
    .fu_data_i      (fu_data),
    .commit_valid_i (commit_valid),
    .commit_id_i    (commit_id),
    .commit_kill_i  (commit_kill),
    .result_valid_o (result_valid),
    .result_ready_i (result_ready),
    .result_id_o    (result_id),
    .result_rd_o    (result_rd),
    .result_data_o  (result_data),
    .result_we_o    (result_we),
    .count_o        (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance past the next rising edge; outputs are then sampled mid-cycle.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", count); end
    checks++; if (fu_ready !== 1'b1) begin errors++; $display("FAIL reset_fu_ready: got %b want 1", fu_ready); end
    checks++; if (result_valid !== 1'b0 || result_we !== 1'b0) begin
      errors++; $display("FAIL reset_valid_we: got %b/%b want 0/0", result_valid, result_we);
    end
    checks++; if (result_id !== 4'd0 || result_rd !== 5'd0 || result_data !== 32'd0) begin
      errors++; $display("FAIL reset_result_zero: got id=%0d rd=%0d data=%h want 0", result_id,
                         result_rd, result_data);
    end
  endtask

  task automatic test_commit_after_push();
    fu_valid = 1'b1; fu_id = 4'd3; fu_rd = 5'd5; fu_data = 32'hDEAD_BEEF;
    tick();
    fu_valid = 1'b0;
    checks++; if (count !== 3'd1) begin errors++; $display("FAIL cap_count1: got %0d want 1", count); end
    checks++; if (result_valid !== 1'b0) begin errors++; $display("FAIL cap_wait1: got %b want 0", result_valid); end
    tick();
    checks++; if (result_valid !== 1'b0) begin errors++; $display("FAIL cap_wait2: got %b want 0", result_valid); end
    commit_valid = 1'b1; commit_id = 4'd3; commit_kill = 1'b0;
    tick();
    commit_valid = 1'b0;
    checks++; if (result_valid !== 1'b1 || result_we !== 1'b1) begin
      errors++; $display("FAIL cap_valid: got valid=%b we=%b want 1/1", result_valid, result_we);
    end
    checks++; if (result_id !== 4'd3 || result_rd !== 5'd5 || result_data !== 32'hDEAD_BEEF) begin
      errors++; $display("FAIL cap_payload: got id=%0d rd=%0d data=%h want 3/5/deadbeef", result_id,
                         result_rd, result_data);
    end
    result_ready = 1'b1;
    tick();
    result_ready = 1'b0;
    checks++; if (count !== 3'd0 || result_valid !== 1'b0) begin
      errors++; $display("FAIL cap_pop: got count=%0d valid=%b want 0/0", count, result_valid);
    end
  endtask

  task automatic test_early_commit();
    commit_valid = 1'b1; commit_id = 4'd7; commit_kill = 1'b0;
    tick();
    commit_valid = 1'b0;
    checks++; if (count !== 3'd0 || result_valid !== 1'b0) begin
      errors++; $display("FAIL early_idle: got count=%0d valid=%b want 0/0", count, result_valid);
    end
    tick();
    tick();
    fu_valid = 1'b1; fu_id = 4'd7; fu_rd = 5'd9; fu_data = 32'h0000_7777;
    tick();
    fu_valid = 1'b0;
    checks++; if (result_valid !== 1'b1 || result_id !== 4'd7 || result_data !== 32'h0000_7777) begin
      errors++; $display("FAIL early_valid: got valid=%b id=%0d data=%h want 1/7/00007777",
                         result_valid, result_id, result_data);
    end
    result_ready = 1'b1;
    tick();
    result_ready = 1'b0;
    // Push ID 7 again without commit: it must wait, proving the scoreboard bit was consumed.
    fu_valid = 1'b1; fu_id = 4'd7; fu_rd = 5'd1; fu_data = 32'h1;
    tick();
    fu_valid = 1'b0;
    tick();
    checks++; if (result_valid !== 1'b0 || count !== 3'd1) begin
      errors++; $display("FAIL early_sb_clear: got valid=%b count=%0d want 0/1", result_valid, count);
    end
    commit_valid = 1'b1; commit_id = 4'd7; commit_kill = 1'b0;
    tick();
    commit_valid = 1'b0;
    result_ready = 1'b1;
    tick();
    result_ready = 1'b0;
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL early_drain: got %0d want 0", count); end
  endtask

  task automatic test_kill();
    fu_valid = 1'b1; fu_id = 4'd1; fu_rd = 5'd11; fu_data = 32'h1111_1111;
    tick();
    fu_id = 4'd2; fu_rd = 5'd12; fu_data = 32'h2222_2222;
    tick();
    fu_valid = 1'b0;
    checks++; if (count !== 3'd2) begin errors++; $display("FAIL kill_count2: got %0d want 2", count); end
    result_ready = 1'b1;
    commit_valid = 1'b1; commit_id = 4'd1; commit_kill = 1'b1;
    tick();
    commit_id = 4'd2; commit_kill = 1'b0;
    checks++; if (result_valid !== 1'b0 || count !== 3'd2) begin
      errors++; $display("FAIL kill_head_hidden: got valid=%b count=%0d want 0/2", result_valid, count);
    end
    tick();
    commit_valid = 1'b0;
    checks++; if (count !== 3'd1) begin errors++; $display("FAIL kill_count1: got %0d want 1", count); end
    checks++; if (result_valid !== 1'b1 || result_id !== 4'd2 || result_data !== 32'h2222_2222) begin
      errors++; $display("FAIL kill_id2_out: got valid=%b id=%0d data=%h want 1/2/22222222",
                         result_valid, result_id, result_data);
    end
    tick();
    result_ready = 1'b0;
    checks++; if (count !== 3'd0 || result_valid !== 1'b0) begin
      errors++; $display("FAIL kill_count0: got count=%0d valid=%b want 0/0", count, result_valid);
    end
  endtask

  task automatic test_full_wrap();
    result_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      fu_valid = 1'b1; fu_id = 4'(k); fu_rd = 5'(k + 10); fu_data = 32'hA000_0000 + 32'(k);
      commit_valid = 1'b1; commit_id = 4'(k); commit_kill = 1'b0;
      tick();
      checks++; if (result_valid !== 1'b1 || result_id !== 4'd0 || result_rd !== 5'd10 ||
                    result_data !== 32'hA000_0000) begin
        errors++; $display("FAIL full_hold_%0d: got valid=%b id=%0d rd=%0d data=%h want 1/0/10/a0000000",
                           k, result_valid, result_id, result_rd, result_data);
      end
    end
    commit_valid = 1'b0;
    checks++; if (count !== 3'd4 || fu_ready !== 1'b0) begin
      errors++; $display("FAIL full_state: got count=%0d fu_ready=%b want 4/0", count, fu_ready);
    end
    // Full and popping in the same cycle: the push of ID 9 must still be refused.
    fu_valid = 1'b1; fu_id = 4'd9; fu_rd = 5'd9; fu_data = 32'h9999_9999;
    result_ready = 1'b1;
    for (int k = 1; k < 4; k++) begin
      tick();
      fu_valid = 1'b0;
      checks++; if (result_valid !== 1'b1 || result_id !== 4'(k) || result_rd !== 5'(k + 10) ||
                    result_data !== 32'hA000_0000 + 32'(k) || count !== 3'(4 - k)) begin
        errors++; $display("FAIL wrap_out_%0d: got valid=%b id=%0d rd=%0d data=%h count=%0d want 1/%0d/%0d/%h/%0d",
                           k, result_valid, result_id, result_rd, result_data, count, k, k + 10,
                           32'hA000_0000 + 32'(k), 4 - k);
      end
    end
    tick();
    result_ready = 1'b0;
    checks++; if (count !== 3'd0 || result_valid !== 1'b0) begin
      errors++; $display("FAIL wrap_empty: got count=%0d valid=%b want 0/0", count, result_valid);
    end
  endtask

  task automatic test_push_commit_during_pop();
    fu_valid = 1'b1; fu_id = 4'd5; fu_rd = 5'd15; fu_data = 32'h5555_5555;
    commit_valid = 1'b1; commit_id = 4'd5; commit_kill = 1'b0;
    tick();
    checks++; if (result_valid !== 1'b1 || result_id !== 4'd5 || count !== 3'd1) begin
      errors++; $display("FAIL pcp_first: got valid=%b id=%0d count=%0d want 1/5/1", result_valid,
                         result_id, count);
    end
    fu_id = 4'd4; fu_rd = 5'd14; fu_data = 32'h4444_4444; commit_id = 4'd4;
    result_ready = 1'b1;
    tick();
    fu_valid = 1'b0; result_ready = 1'b0;
    checks++; if (count !== 3'd1 || result_valid !== 1'b1 || result_id !== 4'd4 ||
                  result_data !== 32'h4444_4444) begin
      errors++; $display("FAIL pcp_same_cycle: got count=%0d valid=%b id=%0d data=%h want 1/1/4/44444444",
                         count, result_valid, result_id, result_data);
    end
    // A kill for an ID that is already READY is ignored and must not reach the scoreboard.
    commit_id = 4'd4; commit_kill = 1'b1;
    tick();
    commit_valid = 1'b0; commit_kill = 1'b0;
    checks++; if (result_valid !== 1'b1 || result_id !== 4'd4) begin
      errors++; $display("FAIL pcp_late_kill: got valid=%b id=%0d want 1/4", result_valid, result_id);
    end
    result_ready = 1'b1;
    tick();
    result_ready = 1'b0;
    fu_valid = 1'b1; fu_id = 4'd4; fu_rd = 5'd14; fu_data = 32'h4;
    tick();
    fu_valid = 1'b0;
    tick();
    checks++; if (count !== 3'd1 || result_valid !== 1'b0) begin
      errors++; $display("FAIL pcp_no_sb_kill: got count=%0d valid=%b want 1/0", count, result_valid);
    end
    commit_valid = 1'b1; commit_id = 4'd4; commit_kill = 1'b0;
    tick();
    commit_valid = 1'b0;
    result_ready = 1'b1;
    tick();
    result_ready = 1'b0;
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL pcp_drain: got %0d want 0", count); end
  endtask

  task automatic test_reset_flush();
    for (int k = 10; k < 13; k++) begin
      fu_valid = 1'b1; fu_id = 4'(k); fu_rd = 5'(k); fu_data = 32'(k);
      tick();
    end
    fu_valid = 1'b0;
    checks++; if (count !== 3'd3) begin errors++; $display("FAIL flush_pending: got %0d want 3", count); end
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    checks++; if (count !== 3'd0 || result_valid !== 1'b0 || fu_ready !== 1'b1) begin
      errors++; $display("FAIL flush_reset: got count=%0d valid=%b fu_ready=%b want 0/0/1", count,
                         result_valid, fu_ready);
    end
    result_ready = 1'b1;
    for (int k = 10; k < 13; k++) begin
      commit_valid = 1'b1; commit_id = 4'(k); commit_kill = 1'b0;
      tick();
      checks++; if (result_valid !== 1'b0 || count !== 3'd0) begin
        errors++; $display("FAIL flush_commit_%0d: got valid=%b count=%0d want 0/0", k, result_valid,
                           count);
      end
    end
    commit_valid = 1'b0;
    tick();
    result_ready = 1'b0;
    checks++; if (result_valid !== 1'b0 || result_id !== 4'd0) begin
      errors++; $display("FAIL flush_quiet: got valid=%b id=%0d want 0/0", result_valid, result_id);
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst_i = 1'b1;
    fu_valid = 1'b0; fu_id = '0; fu_rd = '0; fu_data = '0;
    commit_valid = 1'b0; commit_id = '0; commit_kill = 1'b0;
    result_ready = 1'b0;
    tick();
    tick();
    test_reset();
    test_commit_after_push();
    test_early_commit();
    test_kill();
    test_full_wrap();
    test_push_commit_during_pop();
    test_reset_flush();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
